// File: rtl/hwpe_dma_loader_pkg.sv
// Shared types, HWPE memory map constants and phase sequencing helpers for hwpe_dma_loader.
// The address constants mirror the SoC-level HWPE defines for this build.
package hwpe_dma_loader_pkg;

  localparam int HWPE_ADDR_WIDTH = 16;
  localparam logic [HWPE_ADDR_WIDTH-1:0] FMEM_ADDR2_START = 16'h4000;
  localparam logic [HWPE_ADDR_WIDTH-1:0] KMEM_ADDR_START  = 16'hC000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_KERN,
    S_DRAIN
  } state_e;

  // Both fmap banks share one word count, so F1 and F2 are skipped together.
  function automatic state_e first_phase(input logic [15:0] fw, input logic [15:0] kw);
    if (fw != 16'd0) return S_F1;
    if (kw != 16'd0) return S_KERN;
    return S_DRAIN;
  endfunction

  function automatic state_e next_phase(input state_e s, input logic [15:0] kw);
    case (s)
      S_F1:    return S_F2;
      S_F2:    return (kw != 16'd0) ? S_KERN : S_DRAIN;
      default: return S_DRAIN;
    endcase
  endfunction

endpackage

// File: rtl/hwpe_dma_addr_fifo.sv
// Synchronous FIFO holding HWPE destination addresses of in-flight source reads.
module hwpe_dma_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/hwpe_dma_loader.sv
// Preloads HWPE fmap bank1, fmap bank2 and kernel SRAMs from a source memory port.
// Optional HWPE_DMA_LOADER_CSUM_EN adds a running XOR checksum output of all written words.
module hwpe_dma_loader
  import hwpe_dma_loader_pkg::*;
#(
  parameter int AW        = HWPE_ADDR_WIDTH,
  parameter int SAW       = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic [SAW-1:0] cfg_fmap_base,
  input  logic [SAW-1:0] cfg_fmap2_off,
  input  logic [15:0]    cfg_fmap_words,
  input  logic [SAW-1:0] cfg_kern_base,
  input  logic [15:0]    cfg_kern_words,
  output logic           busy,
  output logic           done,
  output logic           fmap_done,
  output logic           kern_done,
  output logic           src_req_valid,
  input  logic           src_req_ready,
  output logic [SAW-1:0] src_req_addr,
  input  logic           src_rsp_valid,
  input  logic [63:0]    src_rsp_data,
  output logic           dma_wen,
  output logic [AW-1:0]  dma_wa,
  output logic [63:0]    dma_wd,
  output logic           err
`ifdef HWPE_DMA_LOADER_CSUM_EN
  ,
  output logic [63:0]    csum
`endif
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  state_e         state;
  logic [15:0]    cnt, fmap_words_q, kern_words_q, phase_words;
  logic [SAW-1:0] fmap_base_q, fmap2_off_q, kern_base_q, src_base;
  logic [AW-1:0]  dst_base, dst_addr, fifo_head;
  logic [17:0]    wr_cnt, fmap_total, all_total;
  logic [CW-1:0]  outst;
  logic           fifo_empty, fifo_full, push, pop, req_phase, last_req;
  logic           vld_p1;
  logic [AW-1:0]  wa_p1;
  logic [63:0]    wd_p1;

  always_comb begin
    phase_words = 16'd0;
    src_base    = '0;
    dst_base    = '0;
    case (state)
      S_F1: begin
        phase_words = fmap_words_q;
        src_base    = fmap_base_q;
      end
      S_F2: begin
        phase_words = fmap_words_q;
        src_base    = fmap_base_q + fmap2_off_q;
        dst_base    = AW'(FMEM_ADDR2_START);
      end
      S_KERN: begin
        phase_words = kern_words_q;
        src_base    = kern_base_q;
        dst_base    = AW'(KMEM_ADDR_START);
      end
      default: ;
    endcase
  end

  // Request issue: valid depends only on registered state, so it holds until accepted.
  assign req_phase     = (state == S_F1) || (state == S_F2) || (state == S_KERN);
  assign src_req_valid = req_phase && !fifo_full;
  assign src_req_addr  = src_base + SAW'({cnt, 3'b000});
  assign dst_addr      = dst_base + AW'({cnt, 3'b000});
  assign push          = src_req_valid && src_req_ready;
  assign pop           = src_rsp_valid && !fifo_empty;
  assign last_req      = (cnt == phase_words - 16'd1);
  assign fmap_total    = {1'b0, fmap_words_q, 1'b0};
  assign all_total     = fmap_total + {2'b00, kern_words_q};

  hwpe_dma_addr_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (AW)
  ) u_addr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (dst_addr),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (outst)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 16'd0;
      fmap_words_q <= 16'd0;
      kern_words_q <= 16'd0;
      fmap_base_q  <= '0;
      fmap2_off_q  <= '0;
      kern_base_q  <= '0;
      wr_cnt       <= 18'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fmap_done    <= 1'b0;
      kern_done    <= 1'b0;
      err          <= 1'b0;
      vld_p1       <= 1'b0;
      wa_p1        <= '0;
      wd_p1        <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            fmap_base_q  <= cfg_fmap_base;
            fmap2_off_q  <= cfg_fmap2_off;
            fmap_words_q <= cfg_fmap_words;
            kern_base_q  <= cfg_kern_base;
            kern_words_q <= cfg_kern_words;
            cnt          <= 16'd0;
            wr_cnt       <= 18'd0;
            busy         <= 1'b1;
            err          <= 1'b0;
            fmap_done    <= (cfg_fmap_words == 16'd0);
            kern_done    <= (cfg_kern_words == 16'd0);
            state        <= first_phase(cfg_fmap_words, cfg_kern_words);
          end
        end
        S_F1, S_F2, S_KERN: begin
          if (push) begin
            if (last_req) begin
              cnt   <= 16'd0;
              state <= next_phase(state, kern_words_q);
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (outst == '0 && !vld_p1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Write stage: one cycle after the response, in request order.
      vld_p1 <= pop;
      if (pop) begin
        wa_p1  <= fifo_head;
        wd_p1  <= src_rsp_data;
        wr_cnt <= wr_cnt + 18'd1;
        if (wr_cnt + 18'd1 == fmap_total) fmap_done <= 1'b1;
        if (wr_cnt + 18'd1 == all_total)  kern_done <= 1'b1;
      end else if (src_rsp_valid) begin
        err <= 1'b1;
      end
    end
  end

  assign dma_wen = vld_p1;
  assign dma_wa  = wa_p1;
  assign dma_wd  = wd_p1;

`ifdef HWPE_DMA_LOADER_CSUM_EN
  logic [63:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 64'd0;
    end else if (state == S_IDLE && cfg_start) begin
      csum_q <= 64'd0;
    end else if (pop) begin
      csum_q <= csum_q ^ src_rsp_data;
    end
  end

  assign csum = csum_q;
`endif

endmodule
